// File: rtl/vga_frame_fetch_if.sv
// vga_frame_fetch_if: frame-buffer read port between the fetch stage and the frame buffer RAM
interface vga_frame_fetch_if #(parameter int ADDR_W = 18, parameter int DW = 4);
  logic [ADDR_W-1:0] fb_addr;
  logic              fb_re;
  logic [DW-1:0]     fb_data;
  modport master (output fb_addr, fb_re, input fb_data);
  modport slave  (input fb_addr, fb_re, output fb_data);
endinterface

// File: rtl/vga_frame_fetch.sv
// vga_frame_fetch: 2x-upscaled double-buffered frame-buffer fetch with timing realigned to the pixel
module vga_frame_fetch #(
  parameter int FB_W   = 320,
  parameter int FB_H   = 240,
  parameter int DW     = 4,
  parameter int ADDR_W = 18,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [9:0]               x_i,
  input  logic [9:0]               y_i,
  input  logic                     hsync_i,
  input  logic                     vsync_i,
  input  logic                     blankb_i,
  input  logic                     syncb_i,
  vga_frame_fetch_if.master        fb,
  input  logic                     swap_req_i,
  output logic                     swap_ack_o,
  output logic                     buf_sel_o,
  output logic                     hsync_o,
  output logic                     vsync_o,
  output logic                     blankb_o,
  output logic                     syncb_o,
  output logic [3:0]               r_o,
  output logic [3:0]               g_o,
  output logic [3:0]               b_o
);
  typedef enum logic {IDLE, PENDING} state_t;
  localparam logic [4:0] PIPE_RST = 5'b01101;
  state_t state_q, state_d;
  logic vs_prev_q, swap_ack_q, buf_sel_q, commit, y_odd_q, active;
  logic [ADDR_W-1:0] row_q, row_d, addr_q, base;
  logic [4:0] pipe_q [RD_LAT+1];
  logic [3:0] pix, rgb_q, tim_q;
  always_comb begin
    row_d  = y_i == 10'd0 ? '0 : (y_odd_q && !y_i[0]) ? row_q + ADDR_W'(FB_W) : row_q;
    base   = buf_sel_q ? ADDR_W'(FB_W * FB_H) : '0;
    active = blankb_i && x_i < 10'(2 * FB_W) && y_i < 10'(2 * FB_H);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      row_q   <= '0;
      y_odd_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      row_q   <= row_d;
      y_odd_q <= y_i[0];
      if (active) addr_q <= base + row_d + ADDR_W'(x_i[9:1]);
    end
  // each stage carries {active, hsync, vsync, blankb, syncb} alongside the RAM read
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int k = 0; k <= RD_LAT; k++) pipe_q[k] <= PIPE_RST;
      rgb_q <= '0;
      tim_q <= 4'b1101;
    end else begin
      pipe_q[0] <= {active, hsync_i, vsync_i, blankb_i, syncb_i};
      for (int k = 1; k <= RD_LAT; k++) pipe_q[k] <= pipe_q[k-1];
      rgb_q <= pipe_q[RD_LAT][4] ? pix : 4'd0;
      tim_q <= pipe_q[RD_LAT][3:0];
    end
  if (DW >= 4) begin : g_wide
    assign pix = fb.fb_data[DW-1 -: 4];
  end else begin : g_narrow
    assign pix = {fb.fb_data, {(4-DW){1'b0}}};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= IDLE;
      vs_prev_q  <= 1'b1;
      swap_ack_q <= 1'b0;
      buf_sel_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      vs_prev_q  <= vsync_i;
      swap_ack_q <= commit;
      buf_sel_q  <= buf_sel_q ^ commit;
    end
  always_comb state_d = commit ? IDLE : (swap_req_i || state_q == PENDING) ? PENDING : IDLE;
  always_comb commit = vs_prev_q && !vsync_i && (state_q == PENDING || swap_req_i);
  assign fb.fb_addr = addr_q;
  assign fb.fb_re   = pipe_q[0][4];
  assign {hsync_o, vsync_o, blankb_o, syncb_o} = tim_q;
  assign r_o = rgb_q;
  assign g_o = rgb_q;
  assign b_o = rgb_q;
  assign swap_ack_o = swap_ack_q;
  assign buf_sel_o  = buf_sel_q;
endmodule

// File: tb/tb_vga_frame_fetch.sv
// tb_vga_frame_fetch: compressed-raster bench for two latencies against an arithmetic reference model
module tb_vga_frame_fetch;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [9:0] x = 0, y = 0;
  logic hs = 1, vs = 1, bl = 0, sy = 1, req = 0;
  logic ack [2], bsel [2], ho [2], vo [2], bo [2], so [2];
  logic [3:0] r [2], g [2], bb [2];
  int compared = 0, failed = 0;
  string sfx [2] = '{"_lat1", "_lat3"};
  int lit0 [4] = '{0, 0, 1, 1};
  int xs [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 639, 650, 700};
  int bs_start [6] = '{0, 1, 0, 1, 1, 0};
  int bs_after [6] = '{1, 0, 1, 1, 1, 0};
  int ack_exp  [6] = '{1, 1, 1, 0, 0, 0};

  vga_frame_fetch_if #(.ADDR_W(18), .DW(4)) f1 ();
  vga_frame_fetch_if #(.ADDR_W(18), .DW(4)) f3 ();

  vga_frame_fetch #(.RD_LAT(1)) d1 (.clk(clk), .rst(rst), .x_i(x), .y_i(y), .hsync_i(hs), .vsync_i(vs),
    .blankb_i(bl), .syncb_i(sy), .fb(f1), .swap_req_i(req), .swap_ack_o(ack[0]), .buf_sel_o(bsel[0]),
    .hsync_o(ho[0]), .vsync_o(vo[0]), .blankb_o(bo[0]), .syncb_o(so[0]), .r_o(r[0]), .g_o(g[0]), .b_o(bb[0]));
  vga_frame_fetch #(.RD_LAT(3)) d3 (.clk(clk), .rst(rst), .x_i(x), .y_i(y), .hsync_i(hs), .vsync_i(vs),
    .blankb_i(bl), .syncb_i(sy), .fb(f3), .swap_req_i(req), .swap_ack_o(ack[1]), .buf_sel_o(bsel[1]),
    .hsync_o(ho[1]), .vsync_o(vo[1]), .blankb_o(bo[1]), .syncb_o(so[1]), .r_o(r[1]), .g_o(g[1]), .b_o(bb[1]));

  // frame-buffer RAMs whose contents are simply the low nibble of the address
  logic [3:0] m1, m3 [3];
  always @(posedge clk) begin
    m1    <= f1.fb_addr[3:0];
    m3[0] <= f3.fb_addr[3:0];
    m3[1] <= m3[0];
    m3[2] <= m3[1];
  end
  assign f1.fb_data = m1;
  assign f3.fb_data = m3[2];

  // reference: per-cycle record of what must appear at the pins {pix, hs, vs, bl, sy}
  int cyc;
  logic mb, mpend, mvsp, mack, mre, ma, mfall;
  logic [17:0] maddr;
  logic [7:0] hist [16];
  always @(posedge clk or posedge rst)
    if (rst) begin
      cyc = 0; mb = 0; mpend = 0; mvsp = 1; mack = 0; maddr = 0; mre = 0;
    end else begin
      ma = bl && x < 640 && y < 480;
      if (ma) maddr = 18'(int'(mb) * 76800 + (int'(y) / 2) * 320 + int'(x) / 2);
      mre = ma;
      hist[cyc % 16] = {ma ? maddr[3:0] : 4'd0, hs, vs, bl, sy};
      cyc++;
      mfall = mvsp && !vs;
      mack  = mfall && (mpend || req);
      mpend = !mack && (mpend || req);
      if (mack) mb = !mb;
      mvsp = vs;
    end

  function automatic logic [7:0] expv(int lat);
    int i = cyc - lat - 2;
    return i < 0 ? 8'h0D : hist[i % 16];
  endfunction

  task automatic chk(string n, int a, int e);
    compared++;
    if (a != e) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d at %0t", n, a, e, $time);
    end
  endtask

  logic [7:0] e;
  always @(negedge clk)
    if (!rst) begin
      chk("fbaddr_lat1", f1.fb_addr, maddr);
      chk("fbaddr_lat3", f3.fb_addr, maddr);
      for (int k = 0; k < 2; k++) begin
        e = expv(k ? 3 : 1);
        chk({"fbre", sfx[k]}, k ? f3.fb_re : f1.fb_re, mre);
        chk({"bufsel", sfx[k]}, bsel[k], mb);
        chk({"swapack", sfx[k]}, ack[k], mack);
        chk({"r", sfx[k]}, r[k], e[7:4]);
        chk({"g", sfx[k]}, g[k], e[7:4]);
        chk({"b", sfx[k]}, bb[k], e[7:4]);
        chk({"hsync", sfx[k]}, ho[k], e[3]);
        chk({"vsync", sfx[k]}, vo[k], e[2]);
        chk({"blankb", sfx[k]}, bo[k], e[1]);
        chk({"syncb", sfx[k]}, so[k], e[0]);
      end
    end

  task automatic chk_reset(string n);
    for (int k = 0; k < 2; k++) begin
      chk({n, "_rgb", sfx[k]}, {r[k], g[k], bb[k]}, 0);
      chk({n, "_blankb", sfx[k]}, bo[k], 0);
      chk({n, "_hv", sfx[k]}, {ho[k], vo[k], so[k]}, 7);
      chk({n, "_bufsel", sfx[k]}, bsel[k], 0);
      chk({n, "_ack", sfx[k]}, ack[k], 0);
    end
    chk({n, "_fbre"}, {f1.fb_re, f3.fb_re}, 0);
    chk({n, "_fbaddr"}, f1.fb_addr, 0);
  endtask

  task automatic step(input int xx, input int yy, input logic h, v, b, s, rq);
    x = 10'(xx); y = 10'(yy); hs = h; vs = v; bl = b; sy = s; req = rq;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int f, input int stop_y);
    int off, xx;
    off = bs_start[f] ? 76800 : 0;
    for (int ly = 0; ly < 525; ly++)
      for (int j = 0; j < 11; j++) begin
        xx = xs[j];
        step(xx, ly, j != 10, !(ly == 490 || ly == 491), (xx < 640 && ly <= 480) && !(ly == 5 && xx == 2), j != 9,
             (f == 0 && ly == 100 && j == 0) || (f == 1 && (ly == 50 || ly == 200) && j == 3) ||
             (f == 2 && ly == 490 && j == 0));
        if (ly == stop_y && j == 6) return;
        if (ly == 0 && j < 4) chk("lit_addr_y0", f1.fb_addr, lit0[j] + off);
        if (ly == 2 && j == 4) chk("lit_addr_y2x4", f1.fb_addr, 322 + off);
        if (ly == 479 && j == 8) chk("lit_addr_y479x639", f1.fb_addr, 76799 + off);
        if (ly == 0 && j == 7) chk("lit_pix_before_lat1", r[0], 2);
        if (ly == 0 && j == 8) chk("lit_pix_lat1", r[0], 3);
        if (ly == 0 && j == 9) chk("lit_pix_before_lat3", r[1], 2);
        if (ly == 0 && j == 10) chk("lit_pix_lat3", r[1], 3);
        if (ly == 1 && j == 0) chk("lit_hs_hi_lat1", ho[0], 1);
        if (ly == 1 && j == 1) chk("lit_hs_lo_lat1", ho[0], 0);
        if (ly == 1 && j == 2) chk("lit_hs_hi_lat3", ho[1], 1);
        if (ly == 1 && j == 3) chk("lit_hs_lo_lat3", ho[1], 0);
        if (ly == 5 && j == 2) chk("lit_fbre_blank", f1.fb_re, 0);
        if (ly == 5 && j == 4) chk("lit_rgb_blank", r[0], 0);
        if (ly == 7 && j == 9) chk("lit_fbre_x650", f1.fb_re, 0);
        if (ly == 480 && j == 0) chk("lit_fbre_y480", f1.fb_re, 0);
        if (ly == 489 && j == 10) chk("lit_bufsel_hold", bsel[0], bs_start[f]);
        if (ly == 490 && j == 0) begin
          chk("lit_swapack", ack[0], ack_exp[f]);
          chk("lit_bufsel_swap", bsel[0], bs_after[f]);
        end
        if (ly == 490 && j == 1) chk("lit_swapack_single", ack[0], 0);
      end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 0;
    for (int f = 0; f < 4; f++) frame(f, -1);
    frame(4, 100);
    rst = 1;
    #1;
    chk_reset("midreset");
    x = 0; y = 0; bl = 0; hs = 1; vs = 1; sy = 1; req = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    frame(5, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
